crypton_seq: RTL

CRYPTON_SEQ -- requirements
Module: crypton_seq

---
 rtl/crypton_pkg.sv | 31 +++
 rtl/crypton_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/crypton_pkg.sv
// Shared definitions for the crypton_seq sequencer: register map addresses,
// CTRL/STATUS bit positions and the sequencer state encoding.
package crypton_pkg;

  // Register map (4-bit word addresses)
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h1;
  localparam logic [3:0] ADDR_KEY0    = 4'h2;
  localparam logic [3:0] ADDR_DATA0   = 4'h6;
  localparam logic [3:0] ADDR_RESULT0 = 4'hA;

  // CTRL bits (write-only)
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_CLR = 2;

  // STATUS bits (read-only)
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/crypton_seq.sv
// crypton_seq: register-mapped sequencer for a 128-bit block cipher core.
// Holds KEY/DATA operands, runs LOAD -> START -> WAIT -> CAPTURE, latches the
// core result, times out a stuck core and raises a level interrupt.
//
// Ports:
//   ACLK, ARESET             clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data    single-cycle register write
//   rd_en/rd_addr/rd_data    register read, rd_data registered (1-cycle latency)
//   core_key/core_data       operands to the core (stable while busy)
//   core_load/core_start     one-cycle strobes to the core
//   core_done/core_result    completion pulse and result block from the core
//   core_abort               one-cycle flush strobe on abort or timeout
//   trigger                  high from START through CAPTURE
//   irq                      level completion interrupt, cleared by irq_clr
module crypton_seq
  import crypton_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         rd_en,
  input  logic [3:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  output logic         core_load,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         core_abort,
  output logic         trigger,
  output logic         irq
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  state_t       r_state;
  state_t       w_state_nxt;

  logic [31:0]  r_key    [4];
  logic [31:0]  r_data   [4];
  logic [31:0]  r_result [4];
  logic [15:0]  r_cnt;
  logic [15:0]  r_last_cnt;
  logic         r_done;
  logic         r_timeout;
  logic         r_irq;
  logic         r_core_abort;
  logic [31:0]  r_rd_data;

  logic         w_busy;
  logic         w_ctrl_wr;
  logic         w_abort_wr;
  logic         w_start;
  logic         w_abort;
  logic         w_irq_clr;
  logic [15:0]  w_cnt_now;
  logic         w_timeout_evt;
  logic         w_capture;
  logic         w_wait_exit;
  logic [31:0]  w_rd_mux;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
  assign w_abort_wr = w_ctrl_wr && wr_data[CTRL_ABORT];
  assign w_irq_clr  = w_ctrl_wr && wr_data[CTRL_IRQ_CLR];
  // Abort wins over a simultaneous start; both are meaningless in the wrong state.
  assign w_abort    = w_abort_wr && w_busy;
  assign w_start    = w_ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_ABORT] && !w_busy;

  // WAIT cycles elapsed including the current one, saturating at 0xFFFF.
  assign w_cnt_now  = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;

  // core_done takes priority over a timeout landing in the same cycle.
  assign w_timeout_evt = (r_state == ST_WAIT) && !core_done && !w_abort &&
                         (w_cnt_now >= LP_TIMEOUT);
  assign w_capture     = (r_state == ST_CAPTURE) && !w_abort;
  assign w_wait_exit   = (r_state == ST_WAIT) && (core_done || w_abort || w_timeout_evt);

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_START;
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done)          w_state_nxt = ST_CAPTURE;
        else if (w_timeout_evt) w_state_nxt = ST_IDLE;
      end
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  // State-decoded outputs; all zero in IDLE, which reset forces at once.
  always_comb begin
    core_load  = (r_state == ST_LOAD);
    core_start = (r_state == ST_START);
    trigger    = (r_state == ST_START) || (r_state == ST_WAIT) || (r_state == ST_CAPTURE);
  end

  // Register file, status and counters
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        r_key[i]    <= '0;
        r_data[i]   <= '0;
        r_result[i] <= '0;
      end
      r_cnt        <= '0;
      r_last_cnt   <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_irq        <= 1'b0;
      r_core_abort <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      // Operands are frozen while an operation is in flight.
      if (wr_en && !w_busy) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_addr == ADDR_KEY0 + 4'(i))  r_key[i]  <= wr_data;
          if (wr_addr == ADDR_DATA0 + 4'(i)) r_data[i] <= wr_data;
        end
      end

      if (r_state == ST_START)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= w_cnt_now;

      if (w_wait_exit) r_last_cnt <= w_cnt_now;

      if (w_start)        r_done <= 1'b0;
      else if (w_capture) r_done <= 1'b1;

      if (w_start)            r_timeout <= 1'b0;
      else if (w_timeout_evt) r_timeout <= 1'b1;

      if (w_capture || w_timeout_evt) r_irq <= 1'b1;
      else if (w_irq_clr)             r_irq <= 1'b0;

      r_core_abort <= w_abort || w_timeout_evt;

      if (w_capture) begin
        for (int i = 0; i < 4; i++) r_result[i] <= core_result[32*i +: 32];
      end

      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  // Read decode; CTRL and the unused addresses read as zero.
  always_comb begin
    w_rd_mux = '0;
    if (rd_addr == ADDR_STATUS) begin
      w_rd_mux[STAT_BUSY]              = w_busy;
      w_rd_mux[STAT_DONE]              = r_done;
      w_rd_mux[STAT_TIMEOUT]           = r_timeout;
      w_rd_mux[STAT_CNT_LSB +: 16]     = r_last_cnt;
    end
    for (int i = 0; i < 4; i++) begin
      if (rd_addr == ADDR_KEY0 + 4'(i))    w_rd_mux = r_key[i];
      if (rd_addr == ADDR_DATA0 + 4'(i))   w_rd_mux = r_data[i];
      if (rd_addr == ADDR_RESULT0 + 4'(i)) w_rd_mux = r_result[i];
    end
  end

  assign core_key   = {r_key[3], r_key[2], r_key[1], r_key[0]};
  assign core_data  = {r_data[3], r_data[2], r_data[1], r_data[0]};
  assign core_abort = r_core_abort;
  assign irq        = r_irq;
  assign rd_data    = r_rd_data;

endmodule
